ahb_cpu_req_gen: RTL and testbench

AHB-Lite master traffic generator that models the CPU instruction-fetch port in the I-cache system environment. It drives single-beat 32-bit read transfers into the cache's upstream AHB-Lite slave port. Each address is repeated HOLD times to create hit/miss mixes, and every returned word is checked against an address-derived expected value. The block is non-pipelined: at most one transfer is outstanding at a time.

---
 rtl/ahb_cpu_req_gen.sv | 150 +++++++++++++++
 tb/tb_ahb_cpu_req_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_cpu_req_gen.sv
// AHB-Lite instruction-fetch traffic generator.
// Issues single-beat 32-bit NONSEQ reads, one outstanding at a time, repeating
// each address HOLD times before stepping by one word and wrapping inside
// [ADDR_BASE, ADDR_BASE+ADDR_SPAN). Returned data must equal the address.
module ahb_cpu_req_gen #(
    parameter int unsigned REQ_FREQ_CYCLES = 32'd1,
    parameter int unsigned HOLD            = 32'd10,
    parameter logic [31:0] ADDR_BASE       = 32'h0000_0000,
    parameter logic [31:0] ADDR_SPAN       = 32'h0000_0100
) (
    input  logic        hclk,
    input  logic        hrstn,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic        hmastlock,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp,
    output logic [31:0] xfer_cnt,
    output logic        mismatch,
    output logic        bus_err
);

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [31:0] GAP_LAST      = 32'(REQ_FREQ_CYCLES - 32'd1);
    localparam logic [31:0] HOLD_LAST     = 32'(HOLD - 32'd1);
    localparam logic [31:0] ADDR_LAST     = ADDR_BASE + ADDR_SPAN - 32'd4;

    typedef enum logic [1:0] {
        ST_GAP  = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    state_t      state_q;
    logic [31:0] gap_cnt_q;
    logic [31:0] rep_cnt_q;
    logic [31:0] rep_cnt_d;
    logic [31:0] haddr_q;
    logic [31:0] haddr_d;
    logic [1:0]  htrans_q;
    logic [31:0] xfer_cnt_q;
    logic        mismatch_q;
    logic        bus_err_q;

    // Repeat counter and address to load when the current transfer completes.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        haddr_d   = haddr_q;
        if (rep_cnt_q >= HOLD_LAST) begin
            rep_cnt_d = 32'd0;
            if (haddr_q == ADDR_LAST) begin
                haddr_d = ADDR_BASE;
            end else begin
                haddr_d = haddr_q + 32'd4;
            end
        end else begin
            rep_cnt_d = rep_cnt_q + 32'd1;
        end
    end

    // Transfer FSM: idle gap, address phase, data phase; all outputs registered.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state_q    <= ST_GAP;
            gap_cnt_q  <= 32'd0;
            rep_cnt_q  <= 32'd0;
            haddr_q    <= ADDR_BASE;
            htrans_q   <= HTRANS_IDLE;
            xfer_cnt_q <= 32'd0;
            mismatch_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_GAP: begin
                    htrans_q <= HTRANS_IDLE;
                    if (gap_cnt_q >= GAP_LAST) begin
                        state_q   <= ST_ADDR;
                        htrans_q  <= HTRANS_NONSEQ;
                        gap_cnt_q <= 32'd0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 32'd1;
                    end
                end
                ST_ADDR: begin
                    // Address and NONSEQ stay frozen until the slave accepts.
                    if (hready) begin
                        state_q  <= ST_DATA;
                        htrans_q <= HTRANS_IDLE;
                    end else begin
                        htrans_q <= HTRANS_NONSEQ;
                    end
                end
                ST_DATA: begin
                    htrans_q <= HTRANS_IDLE;
                    if (hresp) begin
                        // ERROR: flag on the first cycle, finish on the second, no data check.
                        bus_err_q <= 1'b1;
                        if (hready) begin
                            state_q    <= ST_GAP;
                            gap_cnt_q  <= 32'd0;
                            xfer_cnt_q <= xfer_cnt_q + 32'd1;
                            rep_cnt_q  <= rep_cnt_d;
                            haddr_q    <= haddr_d;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end else if (hready) begin
                        if (hrdata != haddr_q) begin
                            mismatch_q <= 1'b1;
                        end else begin
                            mismatch_q <= mismatch_q;
                        end
                        state_q    <= ST_GAP;
                        gap_cnt_q  <= 32'd0;
                        xfer_cnt_q <= xfer_cnt_q + 32'd1;
                        rep_cnt_q  <= rep_cnt_d;
                        haddr_q    <= haddr_d;
                    end else begin
                        state_q <= ST_DATA;
                    end
                end
                default: begin
                    state_q   <= ST_GAP;
                    gap_cnt_q <= 32'd0;
                    htrans_q  <= HTRANS_IDLE;
                end
            endcase
        end
    end

    assign haddr     = haddr_q;
    assign htrans    = htrans_q;
    assign xfer_cnt  = xfer_cnt_q;
    assign mismatch  = mismatch_q;
    assign bus_err   = bus_err_q;
    assign hwrite    = 1'b0;
    assign hsize     = 3'b010;
    assign hburst    = 3'b000;
    assign hprot     = 4'b0010;
    assign hmastlock = 1'b0;
    assign hwdata    = 32'h0000_0000;

endmodule

// File: tb/tb_ahb_cpu_req_gen.sv
// Self-checking bench: a reactive AHB slave with randomized wait states,
// ERROR responses and corrupted data, checked against a transfer-level model.
// A second small instance exercises the address wrap and asynchronous reset.
module tb_ahb_cpu_req_gen;

    localparam int unsigned REQ  = 32'd1;
    localparam int unsigned HOLD = 32'd10;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] SPAN = 32'h0000_0100;

    logic        hclk = 1'b0;
    logic        hrstn;
    logic [31:0] haddr, hwdata, hrdata, xfer_cnt;
    logic [1:0]  htrans;
    logic        hwrite, hmastlock, hready, hresp, mismatch, bus_err;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    logic        rst_w_n;
    logic [31:0] haddr_w, hwdata_w, xfer_cnt_w;
    logic [1:0]  htrans_w;
    logic        hwrite_w, hmastlock_w, mismatch_w, bus_err_w;
    logic [2:0]  hsize_w, hburst_w;
    logic [3:0]  hprot_w;

    int vectors = 0;
    int miscompares = 0;

    // Transfer-level reference state.
    int unsigned n_done = 0;
    logic        mis_m  = 1'b0;
    logic        err_m  = 1'b0;

    always #5 hclk = ~hclk;

    ahb_cpu_req_gen #(
        .REQ_FREQ_CYCLES(REQ), .HOLD(HOLD), .ADDR_BASE(BASE), .ADDR_SPAN(SPAN)
    ) dut (
        .hclk(hclk), .hrstn(hrstn), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hmastlock(hmastlock), .hwdata(hwdata), .hrdata(hrdata),
        .hready(hready), .hresp(hresp), .xfer_cnt(xfer_cnt),
        .mismatch(mismatch), .bus_err(bus_err)
    );

    // Wrap instance: always-ready slave that echoes the address as data.
    ahb_cpu_req_gen #(
        .REQ_FREQ_CYCLES(32'd1), .HOLD(32'd1), .ADDR_BASE(32'h0), .ADDR_SPAN(32'h8)
    ) dut_w (
        .hclk(hclk), .hrstn(rst_w_n), .haddr(haddr_w), .htrans(htrans_w),
        .hwrite(hwrite_w), .hsize(hsize_w), .hburst(hburst_w), .hprot(hprot_w),
        .hmastlock(hmastlock_w), .hwdata(hwdata_w), .hrdata(haddr_w),
        .hready(1'b1), .hresp(1'b0), .xfer_cnt(xfer_cnt_w),
        .mismatch(mismatch_w), .bus_err(bus_err_w)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Address of the k-th completed transfer, straight from the walk rules.
    function automatic logic [31:0] model_addr(input int unsigned k);
        int unsigned words;
        words = SPAN / 32'd4;
        return BASE + 32'(32'd4 * ((k / HOLD) % words));
    endfunction

    // One complete transfer as seen by the slave; called at a negedge.
    task automatic do_xfer(input int astall, input int waits, input bit corrupt, input bit err);
        int cnt;
        logic [31:0] a;
        cnt    = 0;
        hready = 1'b1;
        hresp  = 1'b0;
        do begin
            @(negedge hclk);
            cnt++;
        end while (htrans !== 2'b10 && cnt < 60);
        check_eq("gap_len", 32'(cnt), REQ);
        a = model_addr(n_done);
        check_eq("haddr", haddr, a);
        for (int i = 0; i < astall; i++) begin
            hready = 1'b0;
            @(negedge hclk);
            check_eq("astall_htrans", {30'd0, htrans}, 32'd2);
            check_eq("astall_haddr", haddr, a);
        end
        hready = 1'b1;
        @(negedge hclk);
        check_eq("data_htrans", {30'd0, htrans}, 32'd0);
        for (int i = 0; i < waits; i++) begin
            hready = 1'b0;
            hresp  = 1'b0;
            @(negedge hclk);
            check_eq("wait_htrans", {30'd0, htrans}, 32'd0);
            check_eq("wait_xfer_cnt", xfer_cnt, n_done);
            check_eq("wait_haddr", haddr, a);
        end
        if (err) begin
            hresp  = 1'b1;
            hready = 1'b0;
            hrdata = 32'h0BAD_0BAD;
            @(negedge hclk);
            err_m = 1'b1;
            check_eq("err1_bus_err", {31'd0, bus_err}, {31'd0, err_m});
            check_eq("err1_xfer_cnt", xfer_cnt, n_done);
            hready = 1'b1;
        end else begin
            hready = 1'b1;
            hrdata = corrupt ? 32'hDEAD_BEEF : a;
            if (corrupt) mis_m = 1'b1;
        end
        @(negedge hclk);
        n_done++;
        check_eq("xfer_cnt", xfer_cnt, n_done);
        check_eq("mismatch", {31'd0, mismatch}, {31'd0, mis_m});
        check_eq("bus_err", {31'd0, bus_err}, {31'd0, err_m});
        check_eq("gap_htrans", {30'd0, htrans}, 32'd0);
        hresp  = 1'b0;
        hready = 1'b1;
        hrdata = 32'd0;
    endtask

    initial begin
        int cnt;
        hrstn   = 1'b0;
        rst_w_n = 1'b0;
        hready  = 1'b1;
        hresp   = 1'b0;
        hrdata  = 32'd0;
        #12;
        check_eq("rst_htrans", {30'd0, htrans}, 32'd0);
        check_eq("rst_haddr", haddr, BASE);
        check_eq("rst_xfer_cnt", xfer_cnt, 32'd0);
        check_eq("rst_flags", {30'd0, mismatch, bus_err}, 32'd0);
        check_eq("const_ctrl", {19'd0, hwrite, hsize, hburst, hprot, hmastlock}, {19'd0, 1'b0, 3'b010, 3'b000, 4'b0010, 1'b0});
        check_eq("const_hwdata", hwdata, 32'd0);
        #16 hrstn = 1'b1;
        @(negedge hclk);
        check_eq("post_rst_idle", {30'd0, htrans}, 32'd0);

        // Ten clean transfers at the base address.
        for (int i = 0; i < 10; i++) do_xfer(0, 0, 1'b0, 1'b0);
        // Second address: ERROR, wait states, bad data, then clean to 20.
        do_xfer(0, 0, 1'b0, 1'b1);
        do_xfer(0, 3, 1'b0, 1'b0);
        do_xfer(0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) do_xfer(0, 0, 1'b0, 1'b0);
        check_eq("cnt_after_20", xfer_cnt, 32'd20);
        // Long stalls in both phases.
        do_xfer(2, 25, 1'b0, 1'b0);
        // Randomized traffic, long enough to wrap the address walk.
        for (int i = 0; i < 660; i++) begin
            int  a_st, w_st;
            bit  e, c;
            a_st = ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0;
            w_st = ($urandom % 3 == 0) ? int'($urandom_range(1, 4)) : 0;
            e    = ($urandom % 10 == 0);
            c    = !e && ($urandom % 16 == 0);
            do_xfer(a_st, w_st, c, e);
        end

        // Wrap instance: 0x0, 0x4, 0x0, 0x4 with HOLD=1 and an 8-byte span.
        rst_w_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cnt = 0;
            do begin
                @(negedge hclk);
                cnt++;
            end while (htrans_w !== 2'b10 && cnt < 20);
            check_eq("w_nonseq", {30'd0, htrans_w}, 32'd2);
            check_eq("w_haddr", haddr_w, (i % 2 == 1) ? 32'h4 : 32'h0);
            check_eq("w_xfer_cnt", xfer_cnt_w, 32'(i));
            @(negedge hclk);
        end
        check_eq("w_data_htrans", {30'd0, htrans_w}, 32'd0);
        check_eq("w_data_haddr", haddr_w, 32'h4);
        #2 rst_w_n = 1'b0;
        #1;
        check_eq("w_rst_htrans", {30'd0, htrans_w}, 32'd0);
        check_eq("w_rst_haddr", haddr_w, 32'h0);
        check_eq("w_rst_xfer_cnt", xfer_cnt_w, 32'd0);
        check_eq("w_mismatch", {31'd0, mismatch_w}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Run-away guard.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", vectors);
        $fatal(1, "watchdog");
    end

endmodule
